// File: rtl/tail_light_pkg.sv
// ---------------------------------------------------------------------------
// tail_light_pkg
//   Shared types and defaults for the tail-light sequencer.
//   - tl_state_e     : sequencer state (IDLE, LEFT, RIGHT, HAZ)
//   - DEF_LAMPS      : default lamps per side
//   - DEF_TICK_DIV   : default clk cycles per animation step
// ---------------------------------------------------------------------------
package tail_light_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } tl_state_e;

    localparam int DEF_LAMPS    = 3;
    localparam int DEF_TICK_DIV = 1;

endpackage : tail_light_pkg

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Animation prescaler. Counts 0..TICK_DIV-1 and wraps; tick is high for
//   the single cycle in which the count equals TICK_DIV-1. With TICK_DIV=1
//   the count is pinned at 0 and tick is high every cycle.
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears the count to 0
//   tick  : one-cycle step strobe
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    // Keep at least one bit so TICK_DIV=1 still has a legal counter.
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule : tick_gen

// File: rtl/tail_light_seq.sv
// ---------------------------------------------------------------------------
// tail_light_seq
//   Sequential tail-light controller. A turn or hazard request starts a
//   thermometer sweep (inner lamp first) that advances one lamp per tick and
//   always returns to IDLE for at least one tick before the next sweep.
//   Hazard preempts a running turn sweep; a hazard sweep ignores inputs
//   until it completes. Brake lights every side that is not animating.
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high; forces IDLE and dark lamps
//   left    : left-turn request (level)
//   right   : right-turn request (level)
//   hazard  : hazard request (level)
//   brake   : brake request (level), reaches lamps combinationally
//   lamps_l : left lamps, bit 0 innermost
//   lamps_r : right lamps, bit 0 innermost
//   busy    : high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS    = DEF_LAMPS,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] lamps_l,
    output logic [LAMPS-1:0] lamps_r,
    output logic             busy
);

    localparam int SW = $clog2(LAMPS + 1);
    localparam logic [SW-1:0] STEP_ONE = SW'(1);
    localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);

    logic            tick;
    tl_state_e       state_q, state_d;
    logic [SW-1:0]   step_q,  step_d;
    logic [LAMPS-1:0] therm;
    logic [LAMPS-1:0] brake_fill;

    // -----------------------------------------------------------------------
    // Step strobe
    // -----------------------------------------------------------------------
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // -----------------------------------------------------------------------
    // State / step registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state. Requests are only looked at on tick cycles, so a short
    // pulse between ticks is dropped rather than latched.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (hazard || (left && right)) begin
                        state_d = HAZ;
                        step_d  = STEP_ONE;
                    end else if (right) begin
                        state_d = RIGHT;
                        step_d  = STEP_ONE;
                    end else if (left) begin
                        state_d = LEFT;
                        step_d  = STEP_ONE;
                    end
                end
                LEFT, RIGHT: begin
                    // Hazard wins even on the final step of a turn sweep.
                    if (hazard) begin
                        state_d = HAZ;
                        step_d  = STEP_ONE;
                    end else if (step_q < STEP_MAX) begin
                        step_d  = step_q + STEP_ONE;
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
                end
                HAZ: begin
                    if (step_q < STEP_MAX) begin
                        step_d  = step_q + STEP_ONE;
                    end else begin
                        state_d = IDLE;
                        step_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Thermometer pattern: lamp i lit when step > i.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < LAMPS; i++) begin : g_therm
        assign therm[i] = (step_q > SW'(i));
    end

    assign brake_fill = brake ? '1 : '0;

    // -----------------------------------------------------------------------
    // Output decode. Reset is folded in so the lamps stay dark while reset
    // is held even though brake reaches the lamps without a register.
    // -----------------------------------------------------------------------
    always_comb begin
        lamps_l = '0;
        lamps_r = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    lamps_l = brake_fill;
                    lamps_r = brake_fill;
                end
                LEFT: begin
                    lamps_l = therm;
                    lamps_r = brake_fill;
                end
                RIGHT: begin
                    lamps_l = brake_fill;
                    lamps_r = therm;
                end
                HAZ: begin
                    lamps_l = therm;
                    lamps_r = therm;
                end
                default: begin
                    lamps_l = '0;
                    lamps_r = '0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule : tail_light_seq

// File: doc/tail_light_seq.md
TAIL_LIGHT_SEQ -- requirements
Module: tail_light_seq

Interface
REQ-001 Parameter LAMPS, default 3, lamps per side (legal 2..16).
REQ-002 Parameter TICK_DIV, default 1, clk cycles per animation step (legal 1..2^16).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 left  input  1  left-turn request, level, synchronous to clk.
REQ-006 right  input  1  right-turn request, level.
REQ-007 hazard  input  1  hazard request, level.
REQ-008 brake  input  1  brake lamp request, level.
REQ-009 lamps_l  output  LAMPS  left lamps; bit 0 innermost.
REQ-010 lamps_r  output  LAMPS  right lamps; bit 0 innermost.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Prescaler counts 0..TICK_DIV-1 and wraps; tick is high for the one cycle where count = TICK_DIV-1 (TICK_DIV=1: tick every cycle).
REQ-013 State register and step counter (1..LAMPS) change only on cycles with tick high.
REQ-014 States: IDLE, LEFT, RIGHT, HAZ; step counter width clog2(LAMPS+1).
REQ-015 IDLE on tick: hazard or (left and right) -> HAZ step 1; else right -> RIGHT step 1; else left -> LEFT step 1; else stay IDLE.
REQ-016 LEFT/RIGHT/HAZ on tick: step < LAMPS -> step+1; step = LAMPS -> IDLE, step 0.
REQ-017 Hazard preemption: in LEFT or RIGHT, tick with hazard high -> HAZ step 1; no other input affects a running LEFT/RIGHT sequence.
REQ-018 In HAZ, inputs are ignored until the sequence completes to IDLE.
REQ-019 Lamp pattern at step k: lowest k bits set (thermometer, inner-to-outer); LEFT drives lamps_l, RIGHT drives lamps_r, HAZ drives both identically.
REQ-020 Brake overlay: a side not driven by the current sequence shows all ones while brake is high, else zero; in IDLE with brake high both sides all ones.
REQ-021 Outputs are decoded from registered state, step and brake only (Moore plus brake); zero-cycle latency from brake to lamps.
REQ-022 Every sequence passes through IDLE for at least one tick (all non-brake lamps off) before another starts, including held requests.
REQ-023 Request pulses shorter than a tick that do not coincide with a tick are ignored (no latching).

Reset
REQ-024 Reset asserted: state IDLE, step 0, prescaler 0, lamps_l = 0, lamps_r = 0, busy = 0, regardless of brake.
REQ-025 Reset asserted mid-sequence aborts immediately; first tick after release occurs TICK_DIV cycles after the first clk edge following deassertion.

Structure
REQ-026 Shared package tail_light_pkg holds the state enum type (IDLE, LEFT, RIGHT, HAZ) and the default LAMPS/TICK_DIV constants.
REQ-027 Prescaler is a sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick).
REQ-028 No latches; fully specified combinational decode with default branch returning IDLE and zero lamps.

Verification
REQ-029 LAMPS=3, TICK_DIV=1, left held 1 cycle from IDLE -> lamps_l 001,011,111 on consecutive cycles, then 000 with busy=0; lamps_r stays 000.
REQ-030 LAMPS=3, left=right=1 held -> both sides 001,011,111,000 repeating with period 4; hazard=1 gives the same result.
REQ-031 LAMPS=3, RIGHT at step 2 (lamps_r=011), hazard raised -> next cycle both sides 001, then 011, 111, 000.
REQ-032 LAMPS=3, left sequence at step 1 with brake=1 -> lamps_l=001, lamps_r=111; brake dropped -> lamps_r=000 same cycle.
REQ-033 LAMPS=5, TICK_DIV=4, right held -> lamps_r advances 00001..11111 every 4 cycles, 20 cycles to full, then 00000 for 4 cycles.
REQ-034 Reset asserted at LEFT step 2 with brake=1 -> all outputs 0 while reset high; after release, IDLE shows brake all ones.
